// File: rtl/presc_sched_ctrl.sv
// rtl/presc_sched_ctrl.sv - single-clock prescaler scheduler for the GZI/GVI tick path
//
// Purpose: generates a one-cycle tick strobe once per divided period using a
// single down-counter. GZI divides by a fixed ratio; GVI divides by
// GVI_BASE*2^presc. A host config is taken by valid/ready handshake and only
// takes effect at a period boundary, so tick periods are never shortened or
// stretched by a config change.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active-low
//   en         in   run enable (level)
//   cfg_valid  in   config request valid
//   cfg_ready  out  config can be accepted (= ~busy)
//   cfg_mod    in   requested mode: 0=GZI, 1=GVI
//   cfg_presc  in   requested GVI prescale code (ignored for GZI)
//   tick       out  one-cycle strobe per divided period
//   cur_mod    out  active mode
//   cur_presc  out  active prescale code
//   busy       out  accepted config pending, not yet applied
//   cfg_err    out  one-cycle pulse: illegal config was rejected

module presc_sched_ctrl #(
  parameter int CNT_W     = 18,
  parameter int GZI_DIV   = 4,
  parameter int GVI_BASE  = 10,
  parameter int PRESC_MAX = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_mod,
  input  logic [3:0] cfg_presc,
  output logic       tick,
  output logic       cur_mod,
  output logic [3:0] cur_presc,
  output logic       busy,
  output logic       cfg_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               cur_mod_d;
  logic [3:0]         cur_presc_d;
  logic               pend, pend_d;
  logic               pend_mod, pend_mod_d;
  logic [3:0]         pend_presc, pend_presc_d;
  logic               tick_d, busy_d, err_d;

  logic accept, illegal, take;

  // Reload value in CNT_W bits: the base is widened before shifting so the
  // largest GVI code does not truncate.
  function automatic logic [CNT_W-1:0] reload_of(input logic m, input logic [3:0] p);
    if (m)
      return (CNT_W'(GVI_BASE) << p) - CNT_W'(1);
    else
      return CNT_W'(GZI_DIV - 1);
  endfunction

  assign cfg_ready = ~busy;
  assign accept    = cfg_valid & cfg_ready;
  assign illegal   = cfg_mod & (cfg_presc > 4'(PRESC_MAX));
  assign take      = accept & ~illegal;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    cur_mod_d    = cur_mod;
    cur_presc_d  = cur_presc;
    pend_d       = pend;
    pend_mod_d   = pend_mod;
    pend_presc_d = pend_presc;
    busy_d       = busy;
    tick_d       = 1'b0;
    err_d        = accept & illegal;

    case (state)
      IDLE: begin
        cnt_d = '0;
        // No period is running, so a legal config applies immediately.
        if (take) begin
          cur_mod_d   = cfg_mod;
          cur_presc_d = cfg_presc;
        end
        if (en) begin
          state_d = RUN;
          cnt_d   = take ? reload_of(cfg_mod, cfg_presc) : reload_of(cur_mod, cur_presc);
        end
      end

      RUN: begin
        if (!en) begin
          // Leaving RUN: drop the partial period, flush any pending config.
          state_d = IDLE;
          cnt_d   = '0;
          if (pend) begin
            cur_mod_d   = pend_mod;
            cur_presc_d = pend_presc;
            pend_d      = 1'b0;
            busy_d      = 1'b0;
          end else if (take) begin
            cur_mod_d   = cfg_mod;
            cur_presc_d = cfg_presc;
          end
        end else begin
          if (cnt == '0) begin
            tick_d = 1'b1;
            if (pend) begin
              cur_mod_d   = pend_mod;
              cur_presc_d = pend_presc;
              cnt_d       = reload_of(pend_mod, pend_presc);
              pend_d      = 1'b0;
              busy_d      = 1'b0;
            end else begin
              cnt_d = reload_of(cur_mod, cur_presc);
            end
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
          // take implies busy=0, hence no pending entry to collide with;
          // a request on the boundary cycle waits for the next boundary.
          if (take) begin
            pend_d       = 1'b1;
            pend_mod_d   = cfg_mod;
            pend_presc_d = cfg_presc;
            busy_d       = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_mod    <= 1'b0;
      cur_presc  <= 4'd0;
      pend       <= 1'b0;
      pend_mod   <= 1'b0;
      pend_presc <= 4'd0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cur_mod    <= cur_mod_d;
      cur_presc  <= cur_presc_d;
      pend       <= pend_d;
      pend_mod   <= pend_mod_d;
      pend_presc <= pend_presc_d;
      tick       <= tick_d;
      busy       <= busy_d;
      cfg_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_presc_sched_ctrl.sv
// tb/tb_presc_sched_ctrl.sv - directed self-checking bench for presc_sched_ctrl

module tb_presc_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_mod;
  logic [3:0] cfg_presc;
  logic       tick;
  logic       cur_mod;
  logic [3:0] cur_presc;
  logic       busy;
  logic       cfg_err;

  int compared   = 0;
  int mismatched = 0;
  int gap;

  presc_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mod   (cfg_mod),
    .cfg_presc (cfg_presc),
    .tick      (tick),
    .cur_mod   (cur_mod),
    .cur_presc (cur_presc),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until tick is seen high; -1 if it never appears.
  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic send_cfg(input logic m, input logic [3:0] p);
    cfg_valid = 1'b1;
    cfg_mod   = m;
    cfg_presc = p;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_mod = 1'b0; cfg_presc = 4'd0;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_mod", int'(cur_mod), 0);
    chk("rst_presc", int'(cur_presc), 0);
    repeat (2) step();
    rst_n = 1'b1;

    // GZI: RUN entry is the first edge after en rises, tick 4 edges later.
    send_cfg(1'b0, 4'd0);
    chk("gzi_idle_mod", int'(cur_mod), 0);
    en = 1'b1;
    wait_tick(20, gap);
    chk("gzi_first", gap, 5);
    wait_tick(20, gap);
    chk("gzi_period", gap, 4);

    // Switch to GVI presc=0 while running: pending until the boundary.
    send_cfg(1'b1, 4'd0);
    chk("sw_busy", int'(busy), 1);
    chk("sw_ready", int'(cfg_ready), 0);
    chk("sw_mod_old", int'(cur_mod), 0);
    wait_tick(20, gap);
    chk("sw_old_rem", gap, 3);
    chk("sw_mod_new", int'(cur_mod), 1);
    chk("sw_busy_clr", int'(busy), 0);
    wait_tick(30, gap);
    chk("gvi0_period", gap, 10);

    // Illegal presc=15: one-cycle error, nothing else changes.
    send_cfg(1'b1, 4'd15);
    chk("ill_err", int'(cfg_err), 1);
    chk("ill_busy", int'(busy), 0);
    chk("ill_presc", int'(cur_presc), 0);
    step();
    chk("ill_err_clr", int'(cfg_err), 0);
    wait_tick(30, gap);
    chk("ill_rem", gap, 8);
    wait_tick(30, gap);
    chk("ill_period", gap, 10);

    // Accept on the cnt==0 cycle: old period once more, then the new one.
    repeat (9) step();
    send_cfg(1'b1, 4'd1);
    chk("bnd_tick", int'(tick), 1);
    chk("bnd_busy", int'(busy), 1);
    chk("bnd_presc_old", int'(cur_presc), 0);
    wait_tick(40, gap);
    chk("bnd_old_period", gap, 10);
    chk("bnd_presc_new", int'(cur_presc), 1);
    chk("bnd_busy_clr", int'(busy), 0);
    wait_tick(40, gap);
    chk("gvi1_period", gap, 20);

    // Identical config still goes through pending, period unchanged.
    send_cfg(1'b1, 4'd1);
    chk("same_busy", int'(busy), 1);
    wait_tick(40, gap);
    chk("same_rem", gap, 19);
    wait_tick(40, gap);
    chk("same_period", gap, 20);
    chk("same_presc", int'(cur_presc), 1);

    // en falls with a config pending: applied on the IDLE-entry edge.
    send_cfg(1'b0, 4'd0);
    chk("pend_busy", int'(busy), 1);
    en = 1'b0;
    step();
    chk("off_mod", int'(cur_mod), 0);
    chk("off_busy", int'(busy), 0);
    chk("off_tick", int'(tick), 0);
    wait_tick(30, gap);
    chk("off_no_tick", gap, -1);

    // en falls exactly on the cnt==0 cycle: no tick.
    en = 1'b1;
    repeat (4) step();
    chk("zero_cnt", int'(dut.cnt), 0);
    en = 1'b0;
    step();
    chk("zero_no_tick", int'(tick), 0);
    chk("zero_idle_cnt", int'(dut.cnt), 0);

    // presc=14: reload 163839 held without truncation.
    send_cfg(1'b1, 4'd14);
    chk("p14_presc", int'(cur_presc), 14);
    chk("p14_busy", int'(busy), 0);
    en = 1'b1;
    step();
    chk("p14_reload", int'(dut.cnt), 163839);
    repeat (100) step();
    chk("p14_count", int'(dut.cnt), 163739);
    chk("p14_no_tick", int'(tick), 0);
    en = 1'b0;
    step();

    // Reset mid-run (while tick is high), then a full fresh first period.
    send_cfg(1'b1, 4'd2);
    en = 1'b1;
    wait_tick(100, gap);
    chk("p2_first", gap, 41);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick", int'(tick), 0);
    chk("arst_mod", int'(cur_mod), 0);
    chk("arst_presc", int'(cur_presc), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    chk("arst_cnt", int'(dut.cnt), 0);
    #2 rst_n = 1'b1;
    wait_tick(20, gap);
    chk("arst_restart", gap, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
